stride_counter: RTL and testbench
=================================

STRIDE_COUNTER -- requirements
Module: stride_counter

Interface
REQ-001 The block SHALL have parameter W, default 4, giving the count width in bits.
REQ-002 The block SHALL have parameter START, default 1, giving the first value after leaving idle.
REQ-003 The block SHALL have parameter STEP, default 2, giving the stride added or subtracted per enabled cycle.
REQ-004 The block SHALL have parameter LIMIT, default 11, giving the upper bound of the sequence.
REQ-005 The block SHALL have parameter MATCH, default 3, giving the count value decoded onto y.
REQ-006 The block SHALL have parameter SATURATE, default 0: 0 wraps at a boundary, 1 stops at it.
REQ-007 The block SHALL have port clock, input, 1 bit: rising-edge clock.
REQ-008 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-009 The block SHALL have port en, input, 1 bit: advance one stride this cycle.
REQ-010 The block SHALL have port dir, input, 1 bit: 0 counts up, 1 counts down.
REQ-011 The block SHALL have port clr, input, 1 bit: synchronous return to idle.
REQ-012 The block SHALL have port count, output, W bits: the registered current value.
REQ-013 The block SHALL have port y, output, 1 bit: Moore decode, high when count==MATCH and state!=IDLE.
REQ-014 The block SHALL have port tc, output, 1 bit: registered pulse, high for the single cycle in which count holds a wrapped value.
REQ-015 The block SHALL have port done, output, 1 bit: high while state==DONE.
REQ-016 The block SHALL have port current_state, output, 2 bits: state encoding IDLE=00, RUN=01, DONE=10.

Function
REQ-017 The block SHALL define LAST = START + STEP*((LIMIT-START)/STEP) as the top value of the sequence.
REQ-018 The block SHALL treat STEP>=1, START<=LIMIT and LIMIT<2**W as legal parameters, and SHALL fail elaboration otherwise.
REQ-019 In IDLE the block SHALL hold count=0; en SHALL move it to RUN, loading count=START when dir=0 or count=LAST when dir=1.
REQ-020 In RUN with dir=0 and en=1, the block SHALL compute count+STEP in W+1 bits; if the result is <=LIMIT it SHALL become the new count, otherwise the boundary rule applies.
REQ-021 In RUN with dir=1 and en=1, if count-STEP>=START (computed without underflow) that value SHALL become the new count, otherwise the boundary rule applies.
REQ-022 The boundary rule SHALL be: when SATURATE=0, count wraps (up to START, down to LAST), the state stays RUN and tc is asserted; when SATURATE=1, count holds, the state goes to DONE and tc stays low.
REQ-023 When en=0, count and state SHALL hold, and tc SHALL be 0.
REQ-024 A change of dir SHALL take effect on the next enabled step, starting from the current count with no extra latency.
REQ-025 In DONE, count SHALL hold and en and dir SHALL be ignored; only clr or reset SHALL leave DONE.
REQ-026 clr=1 SHALL send the block to IDLE with count=0 and tc=0 at the next edge, and SHALL take priority over en in any state.
REQ-027 When START==LAST, every enabled step in RUN SHALL be a boundary event.

Reset
REQ-028 Asserting reset SHALL immediately force state=IDLE, count=0 and tc=0, so that y=0 and done=0, including during operation.
REQ-029 After reset deasserts, the first enabled edge SHALL behave as REQ-019.

Structure
REQ-030 The state encoding and the dir constants SHALL live in the shared package stride_counter_pkg.
REQ-031 The next-value arithmetic (add/subtract, boundary detect, wrap value) SHALL be the combinational sub-module stride_step, instantiated once.

Verification
REQ-032 With defaults, dir=0 and en held high for 8 cycles after reset, count SHALL run 0,1,3,5,7,9,11,1; tc SHALL be high only at the second 1; y SHALL be high only at 3.
REQ-033 With defaults, dir=1 and en held high, count SHALL run 0,11,9,7,5,3,1,11, with tc high at the second 11.
REQ-034 With SATURATE=1, LIMIT=10 and dir=0, count SHALL stop at 9 with done=1 and tc never high; en toggling SHALL leave it at 9; clr SHALL give count=0 and IDLE.
REQ-035 With defaults, flipping dir at count=7 SHALL make the next enabled values 5, then 3.
REQ-036 With defaults, reset asserted mid-run at count=9 SHALL give count=0 and y=0 immediately; clr and en high together SHALL give IDLE.

Source files
------------

// File: rtl/stride_counter_pkg.sv
// Shared types and helpers for the stride counter.
//   state_t        : controller state encoding (IDLE=00, RUN=01, DONE=10)
//   DIR_UP/DOWN    : values of the dir input
//   last_value()   : top value of the START..LIMIT sequence for a given stride
//   params_legal() : parameter sanity check used at elaboration
package stride_counter_pkg;

   localparam int unsigned STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   // Largest START + k*STEP that does not exceed LIMIT.
   function automatic int unsigned last_value(input int unsigned start,
                                              input int unsigned step,
                                              input int unsigned limit);
      if (step == 0 || start > limit) return start;
      return start + step * ((limit - start) / step);
   endfunction

   // Legal set: at least one bit, STEP >= 1, START <= LIMIT, LIMIT fits in w bits.
   function automatic bit params_legal(input int unsigned w,
                                       input int unsigned start,
                                       input int unsigned step,
                                       input int unsigned limit);
      return (w >= 1) && (step >= 1) && (start <= limit) &&
             ((64'(limit) >> w) == 64'd0);
   endfunction

endpackage

// File: rtl/stride_counter_step.sv
// stride_step: combinational next-value arithmetic for the stride counter.
//   count      : current counter value
//   dir        : DIR_UP adds STEP, DIR_DOWN subtracts STEP
//   next_c     : in-range next value (valid when boundary_c is low)
//   boundary_c : the step would leave [START, LIMIT]
//   wrap_c     : value to load on a wrapping boundary (START going up, LAST going down)
module stride_step
   import stride_counter_pkg::*;
#(
   parameter int unsigned W     = 4,
   parameter int unsigned START = 1,
   parameter int unsigned STEP  = 2,
   parameter int unsigned LIMIT = 11
) (
   input  logic [W-1:0] count,
   input  logic         dir,
   output logic [W-1:0] next_c,
   output logic         boundary_c,
   output logic [W-1:0] wrap_c
);

   localparam int unsigned LAST = last_value(START, STEP, LIMIT);
   localparam int unsigned XW   = W + 1;

   // A stride larger than LIMIT can never stay in range; it also would not fit XW bits.
   localparam bit             STEP_FITS = (STEP <= LIMIT);
   localparam logic [XW-1:0]  STEP_X    = XW'(STEP);
   localparam logic [XW-1:0]  LIMIT_X   = XW'(LIMIT);
   // count - STEP >= START  <=>  count >= START + STEP, which avoids underflow.
   localparam logic [XW-1:0]  FLOOR_X   = XW'(START) + XW'(STEP);

   logic [XW-1:0] count_x;
   logic [XW-1:0] sum_x;
   logic [XW-1:0] diff_x;

   // Extended-width add/subtract and range check.
   always_comb begin
      count_x    = {1'b0, count};
      sum_x      = count_x + STEP_X;
      diff_x     = count_x - STEP_X;
      next_c     = count;
      boundary_c = 1'b1;
      wrap_c     = W'(START);
      if (dir == DIR_UP) begin
         wrap_c = W'(START);
         if (STEP_FITS && (sum_x <= LIMIT_X)) begin
            next_c     = W'(sum_x);
            boundary_c = 1'b0;
         end
      end else begin
         wrap_c = W'(LAST);
         if (STEP_FITS && (count_x >= FLOOR_X)) begin
            next_c     = W'(diff_x);
            boundary_c = 1'b0;
         end
      end
   end

endmodule

// File: rtl/stride_counter.sv
// stride_counter: up/down counter stepping by STEP between START and LAST,
// wrapping (SATURATE=0) or stopping in DONE (SATURATE=1) at the boundaries.
//   clock         : rising-edge clock
//   reset         : asynchronous, active-high reset
//   en            : advance one stride this cycle
//   dir           : 0 counts up, 1 counts down
//   clr           : synchronous return to IDLE (beats en)
//   count         : registered current value
//   y             : high when count==MATCH outside IDLE
//   tc            : one-cycle pulse while count holds a freshly wrapped value
//   done          : high while in DONE
//   current_state : IDLE=00, RUN=01, DONE=10
module stride_counter
   import stride_counter_pkg::*;
#(
   parameter int unsigned W        = 4,
   parameter int unsigned START    = 1,
   parameter int unsigned STEP     = 2,
   parameter int unsigned LIMIT    = 11,
   parameter int unsigned MATCH    = 3,
   parameter bit          SATURATE = 1'b0
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               en,
   input  logic               dir,
   input  logic               clr,
   output logic [W-1:0]       count,
   output logic               y,
   output logic               tc,
   output logic               done,
   output logic [STATE_W-1:0] current_state
);

   generate
      if (!params_legal(W, START, STEP, LIMIT)) begin : g_bad_params
         $fatal(1, "stride_counter: illegal parameters (need STEP>=1, START<=LIMIT, LIMIT<2**W)");
      end
   endgenerate

   localparam int unsigned LAST       = last_value(START, STEP, LIMIT);
   localparam logic [W-1:0] START_W   = W'(START);
   localparam logic [W-1:0] LAST_W    = W'(LAST);
   // A MATCH outside the count range can never decode.
   localparam bit           MATCH_OK  = ((64'(MATCH) >> W) == 64'd0);
   localparam logic [W-1:0] MATCH_W   = W'(MATCH);

   state_t       state_q, state_n;
   logic [W-1:0] count_n;
   logic         tc_n;
   logic         y_n;
   logic         done_n;

   logic [W-1:0] step_next_c;
   logic         step_boundary_c;
   logic [W-1:0] step_wrap_c;

   stride_step #(
      .W     (W),
      .START (START),
      .STEP  (STEP),
      .LIMIT (LIMIT)
   ) u_step (
      .count      (count),
      .dir        (dir),
      .next_c     (step_next_c),
      .boundary_c (step_boundary_c),
      .wrap_c     (step_wrap_c)
   );

   // State and output registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         count   <= '0;
         tc      <= 1'b0;
         y       <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_q <= state_n;
         count   <= count_n;
         tc      <= tc_n;
         y       <= y_n;
         done    <= done_n;
      end
   end

   // Next state, next count and the decodes of the next registered values.
   always_comb begin
      state_n = state_q;
      count_n = count;
      tc_n    = 1'b0;
      if (clr) begin
         state_n = ST_IDLE;
         count_n = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               count_n = '0;
               if (en) begin
                  state_n = ST_RUN;
                  count_n = (dir == DIR_DOWN) ? LAST_W : START_W;
               end
            end
            ST_RUN: begin
               if (en) begin
                  if (!step_boundary_c) begin
                     count_n = step_next_c;
                  end else if (!SATURATE) begin
                     count_n = step_wrap_c;
                     tc_n    = 1'b1;
                  end else begin
                     state_n = ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               // Held until clr or reset.
            end
            default: begin
               state_n = ST_IDLE;
               count_n = '0;
            end
         endcase
      end
      y_n    = MATCH_OK && (count_n == MATCH_W) && (state_n != ST_IDLE);
      done_n = (state_n == ST_DONE);
   end

   assign current_state = state_q;

endmodule

// File: tb/tb_stride_counter.sv
module tb_stride_counter;

   typedef struct {
      logic       en;
      logic       dir;
      logic       clr;
      logic [3:0] cnt;
      logic       tc;
      logic       y;
      logic       done;
      logic [1:0] st;
   } vec_t;

   logic       clock = 1'b0;
   logic       reset;
   logic       en0, dir0, clr0;
   logic       en1, dir1, clr1;
   logic [3:0] count0, count1;
   logic       y0, y1, tc0, tc1, done0, done1;
   logic [1:0] st0, st1;

   int total = 0;
   int bad   = 0;

   vec_t tbl[$];
   vec_t exp_q[$];

   always #5 clock = ~clock;

   // Defaults: wrap mode, LAST = 11.
   stride_counter u_dut0 (
      .clock (clock), .reset (reset), .en (en0), .dir (dir0), .clr (clr0),
      .count (count0), .y (y0), .tc (tc0), .done (done0), .current_state (st0)
   );

   // Saturating, LIMIT=10 so LAST = 9.
   stride_counter #(.LIMIT(10), .SATURATE(1'b1)) u_dut1 (
      .clock (clock), .reset (reset), .en (en1), .dir (dir1), .clr (clr1),
      .count (count1), .y (y1), .tc (tc1), .done (done1), .current_state (st1)
   );

   function automatic vec_t v(input logic e, input logic d, input logic c,
                              input int cnt, input logic t, input logic yy,
                              input logic dn, input int s);
      vec_t r;
      r.en = e; r.dir = d; r.clr = c; r.cnt = 4'(cnt);
      r.tc = t; r.y = yy; r.done = dn; r.st = 2'(s);
      return r;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic check_outputs(input string tag, input int d, input vec_t e);
      if (d == 0) begin
         chk({tag, " count"}, int'(count0), int'(e.cnt));
         chk({tag, " tc"},    int'(tc0),    int'(e.tc));
         chk({tag, " y"},     int'(y0),     int'(e.y));
         chk({tag, " done"},  int'(done0),  int'(e.done));
         chk({tag, " state"}, int'(st0),    int'(e.st));
      end else begin
         chk({tag, " count"}, int'(count1), int'(e.cnt));
         chk({tag, " tc"},    int'(tc1),    int'(e.tc));
         chk({tag, " y"},     int'(y1),     int'(e.y));
         chk({tag, " done"},  int'(done1),  int'(e.done));
         chk({tag, " state"}, int'(st1),    int'(e.st));
      end
   endtask

   // Drive one cycle on the falling edge, queue its expectation, compare after the rising edge.
   task automatic step(input string tag, input int d, input vec_t x);
      vec_t e;
      @(negedge clock);
      if (d == 0) begin en0 = x.en; dir0 = x.dir; clr0 = x.clr; end
      else        begin en1 = x.en; dir1 = x.dir; clr1 = x.clr; end
      exp_q.push_back(x);
      @(posedge clock);
      #1;
      if (exp_q.size() == 0) begin
         total++; bad++;
         $display("FAIL %s: scoreboard empty", tag);
      end else begin
         e = exp_q.pop_front();
         check_outputs(tag, d, e);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t e;
      reset = 1'b1;
      en0 = 0; dir0 = 0; clr0 = 0;
      en1 = 0; dir1 = 0; clr1 = 0;

      //        en dir clr cnt tc y done st
      tbl.push_back(v(1, 0, 0,  1, 0, 0, 0, 1));
      tbl.push_back(v(1, 0, 0,  3, 0, 1, 0, 1));
      tbl.push_back(v(1, 0, 0,  5, 0, 0, 0, 1));
      tbl.push_back(v(1, 0, 0,  7, 0, 0, 0, 1));
      tbl.push_back(v(1, 0, 0,  9, 0, 0, 0, 1));
      tbl.push_back(v(1, 0, 0, 11, 0, 0, 0, 1));
      tbl.push_back(v(1, 0, 0,  1, 1, 0, 0, 1));   // wrap up
      tbl.push_back(v(0, 0, 0,  1, 0, 0, 0, 1));   // hold
      tbl.push_back(v(1, 0, 0,  3, 0, 1, 0, 1));
      tbl.push_back(v(1, 1, 1,  0, 0, 0, 0, 0));   // clr beats en
      tbl.push_back(v(1, 1, 0, 11, 0, 0, 0, 1));   // load LAST
      tbl.push_back(v(1, 1, 0,  9, 0, 0, 0, 1));
      tbl.push_back(v(1, 1, 0,  7, 0, 0, 0, 1));
      tbl.push_back(v(1, 1, 0,  5, 0, 0, 0, 1));
      tbl.push_back(v(1, 1, 0,  3, 0, 1, 0, 1));
      tbl.push_back(v(1, 1, 0,  1, 0, 0, 0, 1));
      tbl.push_back(v(1, 1, 0, 11, 1, 0, 0, 1));   // wrap down
      tbl.push_back(v(0, 0, 1,  0, 0, 0, 0, 0));
      tbl.push_back(v(1, 0, 0,  1, 0, 0, 0, 1));
      tbl.push_back(v(1, 0, 0,  3, 0, 1, 0, 1));
      tbl.push_back(v(1, 0, 0,  5, 0, 0, 0, 1));
      tbl.push_back(v(1, 0, 0,  7, 0, 0, 0, 1));
      tbl.push_back(v(1, 1, 0,  5, 0, 0, 0, 1));   // dir flip at 7
      tbl.push_back(v(1, 1, 0,  3, 0, 1, 0, 1));
      tbl.push_back(v(1, 0, 0,  5, 0, 0, 0, 1));
      tbl.push_back(v(1, 0, 0,  7, 0, 0, 0, 1));
      tbl.push_back(v(1, 0, 0,  9, 0, 0, 0, 1));

      // Reset state, both instances.
      repeat (2) @(negedge clock);
      e = v(0, 0, 0, 0, 0, 0, 0, 0);
      check_outputs("reset0", 0, e);
      check_outputs("reset1", 1, e);
      @(negedge clock);
      reset = 1'b0;

      for (int i = 0; i < tbl.size(); i++)
         step($sformatf("row%0d", i), 0, tbl[i]);

      // Asynchronous reset mid-run at count 9, checked before any clock edge.
      @(negedge clock);
      en0 = 1'b0;
      #2 reset = 1'b1;
      #1;
      check_outputs("midreset", 0, v(0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clock);
      reset = 1'b0;
      step("post_reset", 0, v(1, 0, 0, 1, 0, 0, 0, 1));
      step("clr_en_run", 0, v(1, 0, 1, 0, 0, 0, 0, 0));
      step("clr_en_idle", 0, v(1, 1, 1, 0, 0, 0, 0, 0));
      step("idle_hold", 0, v(0, 0, 0, 0, 0, 0, 0, 0));

      // Saturating instance: stop at 9 in DONE, ignore en/dir, leave only on clr.
      step("sat1", 1, v(1, 0, 0, 1, 0, 0, 0, 1));
      step("sat3", 1, v(1, 0, 0, 3, 0, 1, 0, 1));
      step("sat5", 1, v(1, 0, 0, 5, 0, 0, 0, 1));
      step("sat7", 1, v(1, 0, 0, 7, 0, 0, 0, 1));
      step("sat9", 1, v(1, 0, 0, 9, 0, 0, 0, 1));
      step("sat_stop", 1, v(1, 0, 0, 9, 0, 0, 1, 2));
      step("sat_en0", 1, v(0, 0, 0, 9, 0, 0, 1, 2));
      step("sat_en1", 1, v(1, 0, 0, 9, 0, 0, 1, 2));
      step("sat_dir", 1, v(1, 1, 0, 9, 0, 0, 1, 2));
      step("sat_clr", 1, v(0, 0, 1, 0, 0, 0, 0, 0));
      step("sat_down", 1, v(1, 1, 0, 9, 0, 0, 0, 1));
      step("sat_down7", 1, v(1, 1, 0, 7, 0, 0, 0, 1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
